// File: rtl/square_root_pkg.sv
// Shared constants for the digit-by-digit square root: default widths and FSM state codes.
package square_root_pkg;

  localparam int IW_DEF   = 11;
  localparam int FRAC_DEF = 5;
  localparam int OW_DEF   = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/square_root_step.sv
// One radix-2 restoring square-root iteration: pulls in two radicand bits, decides one root bit.
// Purely combinational; the rem_in/root_in relationship (rem <= 2*root) keeps everything in OW+2 bits.
module square_root_step #(
  parameter int OW = 8
) (
  input  logic [OW+1:0] rem_in,
  input  logic [OW-1:0] root_in,
  input  logic [1:0]    bits,
  output logic [OW+1:0] rem_out,
  output logic          root_bit
);

  logic [OW+1:0] shifted;
  logic [OW+1:0] trial;

  assign shifted  = (rem_in << 2) | {{OW{1'b0}}, bits};
  assign trial    = {root_in, 2'b01};
  assign root_bit = (shifted >= trial);
  assign rem_out  = root_bit ? (shifted - trial) : shifted;

endmodule

// File: rtl/square_root.sv
// Sequential integer square root of {v2, FRAC zeros}: one root bit per clock, OW CALC cycles.
// Valid/ready on both sides; result registers update only on entry to DONE and hold through IDLE.
module square_root
  import square_root_pkg::*;
#(
  parameter int IW   = IW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int OW   = OW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] v2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] root,
  output logic [OW:0]   rem,
  output logic          busy
);

  localparam int RW = IW + FRAC;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;

  logic [1:0]    state;
  logic [RW-1:0] rad;
  logic [OW-1:0] part;
  logic [OW+1:0] wrem;
  logic [CW-1:0] cnt;

  logic [OW+1:0] rem_nxt;
  logic          root_bit;
  logic [OW-1:0] part_nxt;

  square_root_step #(.OW(OW)) u_step (
    .rem_in   (wrem),
    .root_in  (part),
    .bits     (rad[RW-1:RW-2]),
    .rem_out  (rem_nxt),
    .root_bit (root_bit)
  );

  assign part_nxt  = {part[OW-2:0], root_bit};

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rad   <= '0;
      part  <= '0;
      wrem  <= '0;
      cnt   <= '0;
      root  <= '0;
      rem   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            rad   <= {v2, {FRAC{1'b0}}};
            part  <= '0;
            wrem  <= '0;
            cnt   <= CW'(OW - 1);
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          rad  <= {rad[RW-3:0], 2'b00};
          part <= part_nxt;
          wrem <= rem_nxt;
          if (cnt == '0) begin
            // Publish the final step straight into the output registers as DONE is entered.
            root  <= part_nxt;
            rem   <= rem_nxt[OW:0];
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_root.sv
// Self-checking bench for square_root: directed vector table, stall/reset sequences, full random-stall sweep.
module tb_square_root;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] v2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  root;
  logic [8:0]  rem;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  square_root dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v2        (v2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] v2;
    logic [7:0]  root;
    logic [8:0]  rem;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: largest r with r*r <= x, found by plain counting.
  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Runs one transaction; out_ready toggles randomly while computing, then held low for 'stall' DONE cycles.
  task automatic run_txn(input logic [10:0] x, input int stall,
                         output int r, output int m, output int lat);
    int g;
    g = 0;
    v2 = x;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    out_ready = 1'b0;
    r = int'(root);
    m = int'(rem);
    for (int k = 0; k < stall; k++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_root_stable", int'(root), r);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_accept", int'(in_ready), 1);
    check("out_valid_after_accept", int'(out_valid), 0);
    check("root_held_in_idle", int'(root), r);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, m, lat, x;

    tbl[0] = '{v2: 11'd0,    root: 8'd0,   rem: 9'd0};
    tbl[1] = '{v2: 11'd18,   root: 8'd24,  rem: 9'd0};
    tbl[2] = '{v2: 11'd1,    root: 8'd5,   rem: 9'd7};
    tbl[3] = '{v2: 11'd512,  root: 8'd128, rem: 9'd0};
    tbl[4] = '{v2: 11'd2047, root: 8'd255, rem: 9'd479};

    rst_n = 1'b0; in_valid = 1'b0; v2 = '0; out_ready = 1'b0;
    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_root", int'(root), 0);
    check("reset_rem", int'(rem), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i].v2, 1, r, m, lat);
      check("tbl_root", r, int'(tbl[i].root));
      check("tbl_rem", m, int'(tbl[i].rem));
      check("tbl_latency", lat, 9);
    end

    // Held result under downstream stall.
    run_txn(11'd1800, 5, r, m, lat);
    check("stall_root", r, 240);
    check("stall_rem", m, 0);

    // Reset in the middle of a calculation drops everything at once.
    v2 = 11'd2047; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("midcalc_busy", int'(busy), 1);
    rst_n = 1'b0; #1;
    check("midcalc_rst_in_ready", int'(in_ready), 1);
    check("midcalc_rst_out_valid", int'(out_valid), 0);
    check("midcalc_rst_busy", int'(busy), 0);
    check("midcalc_rst_root", int'(root), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(11'd18, 0, r, m, lat);
    check("post_reset_root", r, 24);
    check("post_reset_rem", m, 0);

    // Full sweep with random stalls, against the counting reference.
    for (int v = 0; v < 2048; v++) begin
      run_txn(11'(v), $urandom_range(0, 3), r, m, lat);
      x = v * 32;
      check("sweep_root", r, isqrt(x));
      check("sweep_rem", m, x - isqrt(x) * isqrt(x));
      check("sweep_latency", lat, 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
